// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects NBTN buttons and decodes one quadrature encoder.
// Define INCOND_AUTOREPEAT_EN to add a per-button autorepeat timer; without it only the debounced rising edge presses.
module input_conditioner #(
    parameter int NBTN       = 5,
    parameter int NSKIP      = 4095,
    parameter int STEPS      = 4,
    parameter int POSW       = 8,
    parameter int REP_DELAY  = 1000,
    parameter int REP_PERIOD = 250
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_in,
    input  logic            rot_a,
    input  logic            rot_b,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic            rot_step,
    output logic            rot_dir,
    output logic [POSW-1:0] rot_pos,
    output logic            rot_err
);

    localparam int CNTW = (NSKIP > 0) ? $clog2(NSKIP + 1) : 1;
    localparam int QW   = $clog2(STEPS + 1) + 1;
    localparam logic [CNTW-1:0]      LOCK_LOAD = CNTW'(NSKIP);
    localparam logic signed [QW-1:0] Q_TOP     = QW'(STEPS);
    localparam logic signed [QW-1:0] Q_BOT     = -Q_TOP;

`ifdef INCOND_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TW      = $clog2(REP_MAX + 1);
    localparam logic [TW-1:0] REP_LOAD_D = TW'(REP_DELAY);
    localparam logic [TW-1:0] REP_LOAD_P = TW'(REP_PERIOD);
`endif

    // Catch configurations the logic below cannot honour at elaboration time.
    if (NBTN < 1) begin : g_bad_nbtn
        $error("input_conditioner: NBTN must be at least 1");
    end
    if (STEPS != 1 && STEPS != 2 && STEPS != 4) begin : g_bad_steps
        $error("input_conditioner: STEPS must be 1, 2 or 4");
    end
    if (REP_DELAY < 2 || REP_PERIOD < 2) begin : g_bad_rep
        $error("input_conditioner: REP_DELAY and REP_PERIOD must be at least 2");
    end

    logic [NBTN-1:0] btn_meta;
    logic [NBTN-1:0] btn_sync;
    logic [1:0]      rot_meta;
    logic [1:0]      rot_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
            rot_meta <= '0;
            rot_sync <= '0;
        end else begin
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
            rot_meta <= {rot_a, rot_b};
            rot_sync <= rot_meta;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        logic [CNTW-1:0] lock_cnt;
        logic            level;
        logic            press;
        logic            rel;
        logic            accept;
`ifdef INCOND_AUTOREPEAT_EN
        logic [TW-1:0]   rep_timer;
`endif

        assign accept = (lock_cnt == '0) && (btn_sync[i] != level);

        // A change is taken only when the lockout has expired; the lockout then masks contact bounce.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lock_cnt  <= '0;
                level     <= 1'b0;
                press     <= 1'b0;
                rel       <= 1'b0;
`ifdef INCOND_AUTOREPEAT_EN
                rep_timer <= '0;
`endif
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                if (lock_cnt != '0) begin
                    lock_cnt <= lock_cnt - 1'b1;
                end else if (accept) begin
                    level    <= btn_sync[i];
                    lock_cnt <= LOCK_LOAD;
                    press    <= btn_sync[i];
                    rel      <= ~btn_sync[i];
                end
`ifdef INCOND_AUTOREPEAT_EN
                if (accept) begin
                    rep_timer <= btn_sync[i] ? REP_LOAD_D : '0;
                end else if (level && rep_timer == TW'(1)) begin
                    press     <= 1'b1;
                    rep_timer <= REP_LOAD_P;
                end else if (level && rep_timer != '0) begin
                    rep_timer <= rep_timer - 1'b1;
                end
`endif
            end
        end

        assign btn_level[i]   = level;
        assign btn_press[i]   = press;
        assign btn_release[i] = rel;
    end

    logic [1:0]             prev_ab;
    logic signed [QW-1:0]   q;
    logic signed [QW-1:0]   q_next;
    logic                   fwd;
    logic                   back;
    logic                   illegal;

    // Transition codes are {prev, current}; CW order is 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        fwd     = 1'b0;
        back    = 1'b0;
        illegal = 1'b0;
        q_next  = q;
        case ({prev_ab, rot_sync})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd     = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: back    = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
            default: ;
        endcase
        if (fwd) begin
            q_next = q + QW'(1);
        end else if (back) begin
            q_next = q - QW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab  <= '0;
            q        <= '0;
            rot_step <= 1'b0;
            rot_dir  <= 1'b0;
            rot_pos  <= '0;
            rot_err  <= 1'b0;
        end else begin
            prev_ab  <= rot_sync;
            rot_step <= 1'b0;
            rot_err  <= illegal;
            if (q_next == Q_TOP) begin
                rot_step <= 1'b1;
                rot_dir  <= 1'b1;
                rot_pos  <= rot_pos + 1'b1;
                q        <= '0;
            end else if (q_next == Q_BOT) begin
                rot_step <= 1'b1;
                rot_dir  <= 1'b0;
                rot_pos  <= rot_pos - 1'b1;
                q        <= '0;
            end else begin
                q <= q_next;
            end
        end
    end

endmodule
